// File: rtl/ram_copy_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_dma_if
// Description : Control and RAM-side bundle for the ram_copy_dma block-copy
//               engine. csum exists only with RAM_COPY_CHECKSUM_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_copy_dma_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  // control unit side
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  // RAM side: port 1 reads, port 2 writes
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  modport master (
    output start, src_addr, dst_addr, length, abort, rd_data,
    input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, csum
  );
  modport slave (
    input  start, src_addr, dst_addr, length, abort, rd_data,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, csum
  );
`else
  modport master (
    output start, src_addr, dst_addr, length, abort, rd_data,
    input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  start, src_addr, dst_addr, length, abort, rd_data,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
`endif
endinterface : ram_copy_dma_if
`default_nettype wire

// File: rtl/ram_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_dma
// Description : One-word-per-clock block copy from RAM port 1 to RAM port 2.
//               Optional write checksum enabled by macro RAM_COPY_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_copy_dma #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  ram_copy_dma_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             rd_ptr_q;
  logic [ADDR_W-1:0]             wr_ptr_q;
  logic [ADDR_W:0]               rem_q;
  logic                          err_q;
  logic [RD_LAT-1:0]             pipe_vld_q;
  logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q;

  logic [ADDR_W-1:0] w_dist;
  logic              w_reject;
  logic              w_accept;
  logic              w_active;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_pend;

  assign w_accept = (state_q == IDLE) && bus.start;
  assign w_active = (state_q == READ) || (state_q == DRAIN);

  // Pointers still hold src/dst while in CHECK, so the hazard test uses them.
  assign w_dist   = wr_ptr_q - rd_ptr_q;
  assign w_reject = (rem_q > c_MAX_LEN) ||
                    ((w_dist != '0) && ({1'b0, w_dist} < rem_q));

  // Entries that still have to travel down the pipe after this cycle.
  if (RD_LAT > 1) begin : g_pend_deep
    assign w_pend = |pipe_vld_q[RD_LAT-2:0];
  end else begin : g_pend_single
    assign w_pend = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    w_rd_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CHECK;
      end
      CHECK: begin
        if (w_reject || (rem_q == '0)) state_d = FIN;
        else                           state_d = READ;
      end
      READ: begin
        if (bus.abort) begin
          state_d = DRAIN;
        end else begin
          w_rd_fire = 1'b1;
          if (rem_q == c_LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_pend) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        rd_ptr_q <= bus.src_addr;
        wr_ptr_q <= bus.dst_addr;
        rem_q    <= bus.length;
        err_q    <= 1'b0;
      end
      if ((state_q == CHECK) && w_reject) err_q <= 1'b1;
      if (w_active && bus.abort)          err_q <= 1'b1;
      if (w_rd_fire) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        rem_q    <= rem_q - c_LEN_ONE;
      end
    end
  end

  // Each read carries its destination address down a RD_LAT-deep pipe so the
  // write lines up with the cycle the RAM presents the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
    end else begin
      pipe_vld_q[0]  <= w_rd_fire;
      pipe_addr_q[0] <= wr_ptr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  assign w_wr_fire = w_active && pipe_vld_q[RD_LAT-1];

  assign bus.busy    = (state_q != IDLE) && (state_q != FIN);
  assign bus.done    = (state_q == FIN);
  assign bus.err     = (state_q == FIN) && err_q;
  assign bus.rd_en   = w_rd_fire;
  assign bus.rd_addr = rd_ptr_q;
  assign bus.wr_en   = w_wr_fire;
  assign bus.wr_addr = pipe_addr_q[RD_LAT-1];
  assign bus.wr_data = w_wr_fire ? bus.rd_data : '0;

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (w_accept) begin
      csum_q <= '0;
    end else if (w_wr_fire) begin
      csum_q <= csum_q + bus.rd_data;
    end
  end

  assign bus.csum = csum_q;
`endif

endmodule : ram_copy_dma
`default_nettype wire

// File: tb/tb_ram_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_copy_dma
// Description : Directed self-checking bench for ram_copy_dma with a 1-clock
//               read-latency RAM model. Checks csum when RAM_COPY_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_copy_dma;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_copy_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model: registered read on port 1, write on port 2, plus a preload port
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.rd_en) begin
      bus.rd_data <= mem[bus.rd_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Starts a transfer and reports the cycle of done (cycle 0 = start edge).
  task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [ADDR_W:0] n, output int done_cyc,
                          output logic err_v, output logic busy1, output logic busy_dn);
    done_cyc = -1; err_v = 1'b0; busy1 = 1'b0; busy_dn = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.length = n;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (c == 1) busy1 = bus.busy;
      if (bus.done) begin
        done_cyc = c; err_v = bus.err; busy_dn = bus.busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin n_fail++;
      $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.done, bus.err}); end
    n_tests++; if ({bus.rd_en, bus.wr_en} !== 2'b00) begin n_fail++;
      $display("FAIL reset_strobes: got %b expected 00", {bus.rd_en, bus.wr_en}); end
    n_tests++; if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== '0) begin n_fail++;
      $display("FAIL reset_buses: rd_addr=%0d wr_addr=%0d wr_data=%0d expected all 0",
               bus.rd_addr, bus.wr_addr, bus.wr_data); end
`ifdef RAM_COPY_CHECKSUM_EN
    n_tests++; if (bus.csum !== 16'd0) begin n_fail++;
      $display("FAIL reset_csum: got %0d expected 0", bus.csum); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc; logic ev, b1, bd; int r0, w0;
    preload(9'd1, 16'd1); preload(9'd2, 16'd4); preload(9'd3, 16'd8);
    r0 = rd_cnt; w0 = wr_cnt;
    run_copy(9'd1, 9'd100, 10'd3, dc, ev, b1, bd);
    n_tests++; if (dc !== 6) begin n_fail++;
      $display("FAIL basic_done_cycle: got %0d expected 6", dc); end
    n_tests++; if (ev !== 1'b0) begin n_fail++;
      $display("FAIL basic_err: got %b expected 0", ev); end
    n_tests++; if ({b1, bd} !== 2'b10) begin n_fail++;
      $display("FAIL basic_busy: cycle1=%b done_cycle=%b expected 1 and 0", b1, bd); end
    n_tests++; if ((rd_cnt - r0 != 3) || (wr_cnt - w0 != 3)) begin n_fail++;
      $display("FAIL basic_counts: reads=%0d writes=%0d expected 3 and 3", rd_cnt - r0, wr_cnt - w0); end
    n_tests++; if ({mem[100], mem[101], mem[102]} !== {16'd1, 16'd4, 16'd8}) begin n_fail++;
      $display("FAIL basic_data: got %0d %0d %0d expected 1 4 8", mem[100], mem[101], mem[102]); end
`ifdef RAM_COPY_CHECKSUM_EN
    n_tests++; if (bus.csum !== 16'd13) begin n_fail++;
      $display("FAIL basic_csum: got %0d expected 13", bus.csum); end
`endif
  endtask

  task automatic test_wrap();
    int dc; logic ev, b1, bd;
    preload(9'd510, 16'd7); preload(9'd511, 16'd9); preload(9'd0, 16'd10); preload(9'd1, 16'd11);
    run_copy(9'd510, 9'd20, 10'd4, dc, ev, b1, bd);
    n_tests++; if ((dc !== 7) || (ev !== 1'b0)) begin n_fail++;
      $display("FAIL wrap_done: cycle=%0d err=%b expected 7 and 0", dc, ev); end
    n_tests++; if ({mem[20], mem[21], mem[22], mem[23]} !== {16'd7, 16'd9, 16'd10, 16'd11}) begin n_fail++;
      $display("FAIL wrap_data: got %0d %0d %0d %0d expected 7 9 10 11", mem[20], mem[21], mem[22], mem[23]); end
`ifdef RAM_COPY_CHECKSUM_EN
    n_tests++; if (bus.csum !== 16'd37) begin n_fail++;
      $display("FAIL wrap_csum: got %0d expected 37", bus.csum); end
`endif
  endtask

  task automatic test_reject();
    int dc; logic ev, b1, bd; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    run_copy(9'd10, 9'd12, 10'd5, dc, ev, b1, bd);
    n_tests++; if ((dc !== 2) || (ev !== 1'b1)) begin n_fail++;
      $display("FAIL fwd_overlap_done: cycle=%0d err=%b expected 2 and 1", dc, ev); end
    run_copy(9'd10, 9'd12, 10'd0, dc, ev, b1, bd);
    n_tests++; if ((dc !== 2) || (ev !== 1'b0)) begin n_fail++;
      $display("FAIL zero_len_done: cycle=%0d err=%b expected 2 and 0", dc, ev); end
    run_copy(9'd0, 9'd0, 10'd513, dc, ev, b1, bd);
    n_tests++; if ((dc !== 2) || (ev !== 1'b1)) begin n_fail++;
      $display("FAIL too_long_done: cycle=%0d err=%b expected 2 and 1", dc, ev); end
    n_tests++; if ((rd_cnt != r0) || (wr_cnt != w0)) begin n_fail++;
      $display("FAIL reject_no_access: reads=%0d writes=%0d expected 0 and 0", rd_cnt - r0, wr_cnt - w0); end
`ifdef RAM_COPY_CHECKSUM_EN
    n_tests++; if (bus.csum !== 16'd0) begin n_fail++;
      $display("FAIL reject_csum: got %0d expected 0", bus.csum); end
`endif
  endtask

  task automatic test_backward();
    int dc; logic ev, b1, bd;
    for (int i = 0; i < 5; i++) preload(ADDR_W'(12 + i), DATA_W'(i + 1));
    run_copy(9'd12, 9'd10, 10'd5, dc, ev, b1, bd);
    n_tests++; if ((dc !== 8) || (ev !== 1'b0)) begin n_fail++;
      $display("FAIL bwd_done: cycle=%0d err=%b expected 8 and 0", dc, ev); end
    n_tests++; if ({mem[10], mem[11], mem[12], mem[13], mem[14]} !==
                   {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}) begin n_fail++;
      $display("FAIL bwd_data: got %0d %0d %0d %0d %0d expected 1 2 3 4 5",
               mem[10], mem[11], mem[12], mem[13], mem[14]); end
  endtask

  task automatic test_abort();
    int dc, first_rd, r0, w0; logic ev;
    preload(9'd200, 16'h11); preload(9'd201, 16'h22); preload(9'd202, 16'h33);
    preload(9'd303, 16'hBEEF);
    r0 = rd_cnt; w0 = wr_cnt; dc = -1; first_rd = -1; ev = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = 9'd200; bus.dst_addr = 9'd300; bus.length = 10'd50;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      if (c == 3) begin  // start while busy must be ignored
        bus.start = 1'b1; bus.src_addr = 9'd0; bus.dst_addr = 9'd5; bus.length = 10'd1;
      end
      if (c == 5) bus.abort = 1'b1;
      #1;
      if (bus.rd_en && first_rd < 0) first_rd = c;
      if (bus.done) begin dc = c; ev = bus.err; break; end
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    n_tests++; if (first_rd !== 2) begin n_fail++;
      $display("FAIL abort_first_read: cycle=%0d expected 2", first_rd); end
    n_tests++; if ((dc !== 7) || (ev !== 1'b1)) begin n_fail++;
      $display("FAIL abort_done: cycle=%0d err=%b expected 7 and 1", dc, ev); end
    n_tests++; if ((rd_cnt - r0 != 3) || (wr_cnt - w0 != 3)) begin n_fail++;
      $display("FAIL abort_counts: reads=%0d writes=%0d expected 3 and 3", rd_cnt - r0, wr_cnt - w0); end
    n_tests++; if ({mem[300], mem[301], mem[302], mem[303]} !== {16'h11, 16'h22, 16'h33, 16'hBEEF}) begin n_fail++;
      $display("FAIL abort_data: got %h %h %h %h expected 0011 0022 0033 beef",
               mem[300], mem[301], mem[302], mem[303]); end
`ifdef RAM_COPY_CHECKSUM_EN
    n_tests++; if (bus.csum !== 16'h66) begin n_fail++;
      $display("FAIL abort_csum: got %h expected 0066", bus.csum); end
`endif
  endtask

  task automatic test_reset_mid();
    int dc, r0, w0; logic ev, b1, bd;
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = 9'd0; bus.dst_addr = 9'd400; bus.length = 10'd20;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if ({bus.rd_en, bus.wr_en, bus.busy, bus.done} !== 4'b0000) begin n_fail++;
      $display("FAIL midrst_outputs: rd_en,wr_en,busy,done=%b expected 0000",
               {bus.rd_en, bus.wr_en, bus.busy, bus.done}); end
    r0 = rd_cnt; w0 = wr_cnt;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++; if ((rd_cnt != r0) || (wr_cnt != w0)) begin n_fail++;
      $display("FAIL midrst_quiet: reads=%0d writes=%0d after reset expected 0 and 0",
               rd_cnt - r0, wr_cnt - w0); end
    run_copy(9'd2, 9'd150, 10'd2, dc, ev, b1, bd);
    n_tests++; if ((dc !== 5) || (ev !== 1'b0)) begin n_fail++;
      $display("FAIL midrst_rerun_done: cycle=%0d err=%b expected 5 and 0", dc, ev); end
    n_tests++; if ({mem[150], mem[151]} !== {16'd4, 16'd8}) begin n_fail++;
      $display("FAIL midrst_rerun_data: got %0d %0d expected 4 8", mem[150], mem[151]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_reject();
    test_backward();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_copy_dma
`default_nettype wire
